// File: rtl/relu_maxpool_pkg.sv
// Shared types for the ReLU + 2x2/stride-2 max-pool stage.
package relu_maxpool_pkg;

  typedef enum logic [1:0] {
    POOL_IDLE  = 2'd0,
    POOL_RUN   = 2'd1,
    POOL_FLUSH = 2'd2,
    POOL_DONE  = 2'd3
  } pool_state_e;

  // Pooled output dimension for a conv map dimension (odd trailing line dropped).
  function automatic int pool_out_dim(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/relu_maxpool_row_buffer.sv
// Holds the horizontal maxima of an even row until the matching odd row arrives.
module pool_row_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 13,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // The discarded trailing column of an odd-width map can address one past the end.
  always_comb begin
    rd_data_o = '0;
    if (int'(rd_addr_i) < DEPTH) rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/relu_maxpool.sv
// Streaming ReLU followed by 2x2/stride-2 max-pool over a channel-major raster stream.
// Handshake: a transfer happens on a port whenever valid && ready on the same rising edge.
module relu_maxpool
  import relu_maxpool_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int MAP_WIDTH   = 26,
  parameter int MAP_HEIGHT  = 26,
  parameter int NUM_FILTERS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [DATA_WIDTH-1:0] out_data,
  output logic                         done,
  output pool_state_e                  dbg_state
);

  localparam int POOL_OUT_W = pool_out_dim(MAP_WIDTH);
  localparam int CW  = $clog2(MAP_WIDTH);
  localparam int RW  = $clog2(MAP_HEIGHT);
  localparam int CHW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int AW  = (POOL_OUT_W > 1) ? $clog2(POOL_OUT_W) : 1;

  pool_state_e           state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  accept, clear_cnt, col_last, row_last, ch_last, last_px;
  logic                  rb_wr, win_done;
  logic [DATA_WIDTH-1:0] pix, hmax, rb_rd, vmax;
  logic [CW-1:0]         col_half;
  logic [AW-1:0]         rb_addr;

  assign in_ready  = (state_q == POOL_RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign done      = (state_q == POOL_DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

  assign col_last = (col_q == CW'(MAP_WIDTH - 1));
  assign row_last = (row_q == RW'(MAP_HEIGHT - 1));
  assign ch_last  = (ch_q == CHW'(NUM_FILTERS - 1));
  assign last_px  = accept && col_last && row_last && ch_last;

  // After ReLU every value is non-negative, so unsigned compares are exact.
  assign pix      = in_data[DATA_WIDTH-1] ? '0 : in_data;
  assign hmax     = (pix > pair_q) ? pix : pair_q;
  assign vmax     = (rb_rd > hmax) ? rb_rd : hmax;
  assign col_half = col_q >> 1;
  assign rb_addr  = col_half[AW-1:0];
  assign rb_wr    = accept && col_q[0] && !row_q[0];
  assign win_done = accept && col_q[0] && row_q[0];

  pool_row_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (POOL_OUT_W),
    .AW        (AW)
  ) u_row_buffer (
    .clk      (clk),
    .wr_en_i  (rb_wr),
    .wr_addr_i(rb_addr),
    .wr_data_i(hmax),
    .rd_addr_i(rb_addr),
    .rd_data_o(rb_rd)
  );

  always_comb begin
    state_d   = state_q;
    clear_cnt = 1'b0;
    case (state_q)
      POOL_IDLE: if (start) begin
        state_d   = POOL_RUN;
        clear_cnt = 1'b1;
      end
      POOL_RUN:   if (last_px) state_d = POOL_FLUSH;
      POOL_FLUSH: if (!out_valid_q || out_ready) state_d = POOL_DONE;
      POOL_DONE:  state_d = POOL_IDLE;
      default:    state_d = POOL_IDLE;
    endcase
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    ch_d   = ch_q;
    pair_d = pair_q;
    if (clear_cnt) begin
      col_d = '0;
      row_d = '0;
      ch_d  = '0;
    end else if (accept) begin
      if (!col_q[0]) pair_d = pix;
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d = '0;
          ch_d  = ch_last ? '0 : ch_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // A completing window can only be accepted when the register is free or draining, so no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (win_done) begin
      out_valid_d = 1'b1;
      out_data_d  = vmax;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= POOL_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      pair_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      pair_q      <= pair_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// Bench for relu_maxpool: three map geometries driven from one directed sequence.
module tb_relu_maxpool;
  import relu_maxpool_pkg::*;

  localparam int NDUT = 3;
  localparam int W_A  [NDUT] = '{4, 5, 2};
  localparam int H_A  [NDUT] = '{4, 5, 2};
  localparam int NF_A [NDUT] = '{1, 2, 2};

  logic        clk = 1'b0;
  logic        reset;
  logic        start     [NDUT];
  logic        in_valid  [NDUT];
  logic        in_ready  [NDUT];
  logic [15:0] in_data   [NDUT];
  logic        out_valid [NDUT];
  logic        out_ready [NDUT];
  logic [15:0] out_data  [NDUT];
  logic        done      [NDUT];
  pool_state_e dbg_state [NDUT];

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Clock and reset
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    relu_maxpool #(
      .DATA_WIDTH (16),
      .FRAC_BITS  (8),
      .MAP_WIDTH  (W_A[g]),
      .MAP_HEIGHT (H_A[g]),
      .NUM_FILTERS(NF_A[g])
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .done     (done[g]),
      .dbg_state(dbg_state[g])
    );
  end

  task automatic check(input string tag, input bit ok, input longint obs, input longint expv);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: ReLU then max over each 2x2 block, trailing odd row/column ignored.
  task automatic build_expected(input int d, input int px[$]);
    int w, h, nf, m, v;
    w = W_A[d]; h = H_A[d]; nf = NF_A[d];
    exp_q.delete();
    for (int c = 0; c < nf; c++)
      for (int r = 0; r < h / 2; r++)
        for (int k = 0; k < w / 2; k++) begin
          m = 0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              v = px[c * w * h + (2 * r + dr) * w + 2 * k + dc];
              if (v > m) m = v;
            end
          exp_q.push_back(16'(m));
        end
  endtask

  // Driver + monitor for one frame; every action happens at the falling edge.
  task automatic run_frame(input int d, input int px[$], input int rdy_pct,
                           input int vld_pct, input int abort_after, output int in_span);
    int n_in, cyc, last_in, last_out, exp_cyc;
    bit done_seen, prev_stall, acc_out;
    logic [15:0] prev_data, exp_v;
    n_in = 0; cyc = 0; last_in = -1; last_out = -1;
    done_seen = 1'b0; prev_stall = 1'b0; prev_data = '0;
    build_expected(d, px);

    @(negedge clk);
    start[d] = 1'b1; in_valid[d] = 1'b1; in_data[d] = 16'h7fff; out_ready[d] = 1'b1;
    #1;
    check("idle_in_ready", in_ready[d] === 1'b0, in_ready[d], 0);
    @(negedge clk);
    start[d] = 1'b0;

    while (!done_seen && cyc < 4000) begin
      out_ready[d] = ($urandom_range(0, 99) < rdy_pct);
      in_valid[d]  = (n_in < px.size()) && ($urandom_range(0, 99) < vld_pct);
      in_data[d]   = in_valid[d] ? 16'(px[n_in]) : 16'h0;
      start[d]     = (abort_after == 0) && ($urandom_range(0, 9) == 0);
      #1;
      if (done[d] === 1'b1) begin
        done_seen = 1'b1;
        exp_cyc = (last_out + 1 > last_in + 2) ? last_out + 1 : last_in + 2;
        check("done_all_out", exp_q.size() == 0, exp_q.size(), 0);
        check("done_all_in", n_in == px.size(), n_in, px.size());
        check("done_timing", cyc == exp_cyc, cyc, exp_cyc);
        check("done_out_valid", out_valid[d] === 1'b0, out_valid[d], 0);
      end else begin
        if (prev_stall) begin
          check("stall_valid", out_valid[d] === 1'b1, out_valid[d], 1);
          check("stall_data", out_data[d] === prev_data, out_data[d], prev_data);
        end
        if (out_valid[d] === 1'b1 && !out_ready[d])
          check("full_in_ready", in_ready[d] === 1'b0, in_ready[d], 0);
        acc_out = (out_valid[d] === 1'b1) && out_ready[d];
        if (acc_out) begin
          if (exp_q.size() == 0) begin
            check("no_extra_out", out_valid[d] === 1'b0, out_valid[d], 0);
          end else begin
            exp_v = exp_q.pop_front();
            check("out_data", out_data[d] === exp_v, out_data[d], exp_v);
            last_out = cyc;
          end
        end
        prev_stall = (out_valid[d] === 1'b1) && !out_ready[d];
        prev_data  = out_data[d];
        if (in_valid[d] && in_ready[d] === 1'b1) begin
          n_in++;
          last_in = cyc;
          if (abort_after > 0 && n_in == abort_after) break;
        end
        @(negedge clk);
        cyc++;
      end
    end
    in_span = last_in + 1;
    if (abort_after > 0) return;
    start[d] = 1'b0; in_valid[d] = 1'b0;
    if (!done_seen) check("done_timeout", done_seen == 1'b1, done_seen, 1);
    @(negedge clk);
    #1;
    check("done_single_pulse", done[d] === 1'b0, done[d], 0);
    check("back_to_idle", dbg_state[d] === POOL_IDLE, dbg_state[d], POOL_IDLE);
    out_ready[d] = 1'b0;
  endtask

  task automatic rand_pixels(input int d, output int px[$]);
    px.delete();
    for (int i = 0; i < W_A[d] * H_A[d] * NF_A[d]; i++)
      px.push_back(int'($urandom_range(0, 65535)) - 32768);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int px[$];
    int span;
    reset = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      start[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < NDUT; i++) begin
      check("rst_out_valid", out_valid[i] === 1'b0, out_valid[i], 0);
      check("rst_out_data", out_data[i] === 16'h0, out_data[i], 0);
      check("rst_done", done[i] === 1'b0, done[i], 0);
      check("rst_in_ready", in_ready[i] === 1'b0, in_ready[i], 0);
      check("rst_state", dbg_state[i] === POOL_IDLE, dbg_state[i], POOL_IDLE);
    end
    @(negedge clk);
    reset = 1'b1;

    // 4x4 ramp, no stalls: 5,7,13,15 at one input per cycle
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back(i);
    run_frame(0, px, 100, 100, 0, span);
    check("full_throughput", span == 16, span, 16);

    // All negative: ReLU forces zeros
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back(-3);
    run_frame(0, px, 100, 100, 0, span);

    // 5x5 ramp, odd trailing column/row discarded; second channel random
    px.delete();
    for (int i = 0; i < 25; i++) px.push_back(i);
    for (int i = 0; i < 25; i++) px.push_back(int'($urandom_range(0, 65535)) - 32768);
    run_frame(1, px, 100, 100, 0, span);

    // 2x2, two channels: 9 then 3
    px = '{1, 9, 4, 2, -1, -5, 0, 3};
    run_frame(2, px, 100, 100, 0, span);

    // Random data with a 30% consumer
    for (int f = 0; f < 3; f++) begin
      rand_pixels(0, px);
      run_frame(0, px, 30, 80, 0, span);
    end
    rand_pixels(1, px);
    run_frame(1, px, 30, 70, 0, span);
    for (int f = 0; f < 2; f++) begin
      rand_pixels(2, px);
      run_frame(2, px, 30, 90, 0, span);
    end

    // Mid-frame reset after 6 inputs, then a clean frame
    rand_pixels(0, px);
    run_frame(0, px, 0, 100, 6, span);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid[0] === 1'b0, out_valid[0], 0);
    check("mid_rst_done", done[0] === 1'b0, done[0], 0);
    check("mid_rst_state", dbg_state[0] === POOL_IDLE, dbg_state[0], POOL_IDLE);
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    @(negedge clk);
    check("mid_rst_hold_valid", out_valid[0] === 1'b0, out_valid[0], 0);
    @(negedge clk);
    reset = 1'b1;
    rand_pixels(0, px);
    run_frame(0, px, 60, 100, 0, span);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/relu_maxpool.md
# relu_maxpool

Streaming ReLU + 2×2/stride-2 max-pool stage directly downstream of `conv_core`. It consumes the convolution output as a raster pixel stream, one feature map per filter, channel-major. It emits the pooled maps in the same order over a valid/ready stream. A `start`/`done` pair lets `cnn_top` sequence it alongside the core.

## Interface
Parameters:
- `DATA_WIDTH`, 16: signed fixed-point sample width, input and output.
- `FRAC_BITS`, 8: fractional bits. Carried for consistency only; max/ReLU do not rescale.
- `MAP_WIDTH`, 26: conv output map width in pixels (≥2).
- `MAP_HEIGHT`, 26: conv output map height in pixels (≥2).
- `NUM_FILTERS`, 4: number of maps per frame.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `reset`, in, 1: one clock; reset is asynchronous and active-low.
- `start`, in, 1: begin a frame; sampled only in IDLE.
- `in_valid`, in, 1: conv pixel valid.
- `in_ready`, out, 1: stage accepts the pixel this cycle.
- `in_data`, in, DATA_WIDTH: signed conv pixel.
- `out_valid`, out, 1: pooled pixel valid.
- `out_ready`, in, 1: consumer accepts the pooled pixel.
- `out_data`, out, DATA_WIDTH: pooled pixel, always ≥0.
- `done`, out, 1: one-cycle pulse when the frame is complete.

## Operation
- Transfer occurs on `valid && ready` for both ports.
- ReLU first: a negative `in_data` becomes 0. All later comparisons are on non-negative values, so they are unsigned-safe; widths are unchanged.
- Counters:
  - `col` runs 0..MAP_WIDTH-1.
  - `row` runs 0..MAP_HEIGHT-1.
  - `ch` runs 0..NUM_FILTERS-1.
  - All three advance on each accepted input, raster order, wrapping col→row→ch.
- Horizontal pair: on even `col`, latch the pixel into `pair_reg`. On odd `col`, form `hmax = max(pair_reg, pixel)`.
- Even `row`, odd `col`: write `hmax` to row buffer entry `col>>1`.
- Odd `row`, odd `col`: output `max(rowbuf[col>>1], hmax)`.
- Odd MAP_WIDTH: the last column is accepted and discarded. Odd MAP_HEIGHT: the last row is accepted and discarded.
- Output per map: floor(W/2) × floor(H/2) pixels, order ch, row, col.
- FSM states:
  - IDLE: `in_ready`=0. `start`=1 → RUN, counters cleared.
  - RUN: accept input. When the last pixel of the last channel is accepted → FLUSH.
  - FLUSH: `in_ready`=0. When the output register is empty (or emptied this cycle) → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored.
- `in_valid` in IDLE/FLUSH/DONE is not accepted.

## Timing
- Reset values: state IDLE; counters 0; `in_ready`=0, `out_valid`=0, `out_data`=0, `done`=0. Row buffer contents are don't-care.
- Latency: a pooled pixel is registered on the edge that accepts the window's bottom-right input. `out_valid` rises the next cycle (1 cycle).
- Single output register. `in_ready = RUN && (!out_valid || out_ready)`: full throughput at one pixel/cycle when the consumer never stalls.
- `out_valid` holds and `out_data` is stable until accepted.
- Simultaneous output accept and new window completion in the same cycle: the register reloads with no bubble.
- `done` asserts exactly one cycle after the final pooled pixel is accepted. When that pixel is accepted the same cycle it becomes registered, `done` follows on the next cycle through FLUSH.
- `reset` asserted mid-frame: immediate return to IDLE, `out_valid` drops asynchronously, any partial frame is lost.

## Structure
- Add to `cnn_params.vh`: `POOL_OUT_W = MAP_WIDTH/2` and `POOL_OUT_H = MAP_HEIGHT/2`. Also the FSM state encodings `POOL_IDLE/RUN/FLUSH/DONE` (2-bit).
- Sub-module `pool_row_buffer`: POOL_OUT_W × DATA_WIDTH register array. One synchronous write port, one combinational read port; same-address read returns the old value.
- Top level holds the counters, `pair_reg`, the FSM and the output register.

## Test plan
- W=H=4, NUM_FILTERS=1, input 0..15 raster, `out_ready`=1 → outputs 5, 7, 13, 15 then `done` pulse. Input accepted one per cycle with no stalls.
- All inputs negative (−3) with W=H=4 → four outputs of 0. ReLU is confirmed.
- W=5, H=5, input 0..24 → outputs 6, 8, 16, 18. Column 4 and row 4 are discarded. `done` follows the 4th accept.
- NUM_FILTERS=2, W=H=2, inputs {1,9,4,2} then {−1,−5,0,3} → outputs 9 then 3. A single `done` pulse at the end.
- Random `out_ready` at 30% duty → no lost or duplicated outputs, `out_data` stable while stalled, `in_ready` low whenever output is full and not accepted.
- Reset asserted after 6 of 16 inputs, then `start` and a full frame → `out_valid`/`done` are 0 during reset and the second frame yields the correct 4 outputs.
